// File: rtl/router_ejector_pkg.sv
// Shared definitions for the router ejection port: channel and credit field
// offsets, VC count and the per-VC receive state machine encoding.
package router_ejector_pkg;

    localparam int NUM_VCS  = 2;

    // Channel from the router output port: {data, tail, head, vc, valid}
    localparam int CH_VALID = 0;
    localparam int CH_VC    = 1;
    localparam int CH_HEAD  = 2;
    localparam int CH_TAIL  = 3;
    localparam int CH_DATA  = 4;

    // Credit returned to the router: {vc, valid}
    localparam int FC_VALID = 0;
    localparam int FC_VC    = 1;
    localparam int FC_WIDTH = 2;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_IN_PKT = 1'b1
    } rx_state_t;

    // A tail always closes the packet; a head without tail opens one.
    function automatic rx_state_t rx_next_state(input rx_state_t cur,
                                                input logic head,
                                                input logic tail);
        if (tail) begin
            return RX_IDLE;
        end
        if (head) begin
            return RX_IN_PKT;
        end
        return cur;
    endfunction

    // Between packets only a head is legal; inside a packet a head is not.
    function automatic logic rx_framing_error(input rx_state_t cur,
                                              input logic head);
        return (cur == RX_IDLE) ? !head : head;
    endfunction

endpackage

// File: rtl/router_ejector_vc_fifo.sv
// Per-VC flit buffer. Pointers wrap modulo DEPTH so any depth works; the
// head entry is read asynchronously so a flit written on one edge is
// presented in the following cycle.
module ejector_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic full;
    logic do_read;
    logic do_write;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign do_read  = rd_en && !empty;
    // A dequeue in the same cycle frees the slot, so a full buffer still accepts.
    assign do_write = wr_en && (!full || do_read);
    assign overflow = wr_en && full && !do_read;
    assign rd_data  = mem[rd_ptr_reg];

    // Storage array: written only, never reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/router_ejector.sv
// Router ejection port: buffers incoming flits per VC, checks packet framing,
// forwards whole packets to the terminal with round-robin VC arbitration and
// returns one credit to the router for every flit handed to the terminal.
module router_ejector
    import router_ejector_pkg::*;
#(
    parameter int BUF_DEPTH  = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH+3:0] channel_in,
    output logic [FC_WIDTH-1:0]   flow_ctrl_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_vc,
    output logic                  out_head,
    output logic                  out_tail,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  error
);

    // Buffered flit layout: {tail, head, data}
    localparam int FLIT_W = DATA_WIDTH + 2;

    logic                  in_valid;
    logic                  in_vc;
    logic                  in_head;
    logic                  in_tail;
    logic [DATA_WIDTH-1:0] in_data;
    logic [FLIT_W-1:0]     in_flit;

    assign in_valid = channel_in[CH_VALID];
    assign in_vc    = channel_in[CH_VC];
    assign in_head  = channel_in[CH_HEAD];
    assign in_tail  = channel_in[CH_TAIL];
    assign in_data  = channel_in[CH_DATA +: DATA_WIDTH];
    assign in_flit  = {in_tail, in_head, in_data};

    logic [NUM_VCS-1:0]             fifo_wr;
    logic [NUM_VCS-1:0]             fifo_rd;
    logic [NUM_VCS-1:0]             fifo_empty;
    logic [NUM_VCS-1:0]             fifo_overflow;
    logic [NUM_VCS-1:0]             frame_err;
    logic [NUM_VCS-1:0][FLIT_W-1:0] fifo_head;

    logic              sel_vc;
    logic [FLIT_W-1:0] sel_flit;
    logic              deq;

    logic              lock_reg;
    logic              lock_vc_reg;
    logic              stall_reg;
    logic              stall_vc_reg;
    logic              rr_prio_reg;
    logic [FC_WIDTH-1:0] flow_ctrl_reg;
    logic              error_reg;

    generate
        for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
            rx_state_t rx_state_reg;

            assign fifo_wr[gi]   = in_valid && (in_vc == 1'(gi));
            assign fifo_rd[gi]   = deq && (sel_vc == 1'(gi));
            assign frame_err[gi] = fifo_wr[gi] && rx_framing_error(rx_state_reg, in_head);

            ejector_vc_fifo #(
                .DEPTH (BUF_DEPTH),
                .WIDTH (FLIT_W)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (fifo_wr[gi]),
                .wr_data  (in_flit),
                .rd_en    (fifo_rd[gi]),
                .rd_data  (fifo_head[gi]),
                .empty    (fifo_empty[gi]),
                .overflow (fifo_overflow[gi])
            );

            // Receive framing tracker; follows the channel even for dropped flits.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rx_state_reg <= RX_IDLE;
                end else if (fifo_wr[gi]) begin
                    rx_state_reg <= rx_next_state(rx_state_reg, in_head, in_tail);
                end
            end
        end
    endgenerate

    // Output VC choice: a packet in flight wins, then a stalled flit must stay
    // put, otherwise the priority VC if it has data, else the other one.
    always_comb begin
        sel_vc = rr_prio_reg;
        if (lock_reg) begin
            sel_vc = lock_vc_reg;
        end else if (stall_reg) begin
            sel_vc = stall_vc_reg;
        end else if (fifo_empty[rr_prio_reg] && !fifo_empty[~rr_prio_reg]) begin
            sel_vc = ~rr_prio_reg;
        end
    end

    assign sel_flit  = fifo_head[sel_vc];
    assign out_valid = !fifo_empty[sel_vc];
    assign out_vc    = sel_vc;
    assign out_tail  = sel_flit[DATA_WIDTH + 1];
    assign out_head  = sel_flit[DATA_WIDTH];
    assign out_data  = sel_flit[DATA_WIDTH-1:0];
    assign deq       = out_valid && out_ready;

    // Arbitration state: packet lock, stall hold and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_reg     <= 1'b0;
            lock_vc_reg  <= 1'b0;
            stall_reg    <= 1'b0;
            stall_vc_reg <= 1'b0;
            rr_prio_reg  <= 1'b0;
        end else begin
            stall_reg    <= out_valid && !out_ready;
            stall_vc_reg <= sel_vc;
            if (deq) begin
                rr_prio_reg <= ~sel_vc;
                if (out_tail) begin
                    lock_reg <= 1'b0;
                end else if (out_head) begin
                    lock_reg    <= 1'b1;
                    lock_vc_reg <= sel_vc;
                end
            end
        end
    end

    // One credit per dequeued flit, presented in the cycle after the dequeue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flow_ctrl_reg <= '0;
        end else begin
            flow_ctrl_reg <= '0;
            if (deq) begin
                flow_ctrl_reg[FC_VALID] <= 1'b1;
                flow_ctrl_reg[FC_VC]    <= sel_vc;
            end
        end
    end

    // Sticky protocol error: overflow or framing violation on either VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_reg <= 1'b0;
        end else if ((|fifo_overflow) || (|frame_err)) begin
            error_reg <= 1'b1;
        end
    end

    assign flow_ctrl_out = flow_ctrl_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_router_ejector.sv
// Self-checking bench for router_ejector: directed scenarios plus a randomized
// run checked against a queue-based packet/credit model.
module tb_router_ejector;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    typedef logic [DW+1:0] flit_t;   // {tail, head, data}

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW+3:0] channel_in = '0;
    logic [1:0]    flow_ctrl_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_vc;
    logic          out_head;
    logic          out_tail;
    logic [DW-1:0] out_data;
    logic          error;

    int tests = 0;
    int fails = 0;

    router_ejector #(
        .BUF_DEPTH  (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .channel_in    (channel_in),
        .flow_ctrl_out (flow_ctrl_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vc        (out_vc),
        .out_head      (out_head),
        .out_tail      (out_tail),
        .out_data      (out_data),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Interleaved-input stimulus and the packet order the terminal must see.
    logic       il_vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       il_hd [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       il_tl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] il_dt [8] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hC0, 8'hD0};
    logic       ex_vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex_dt [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hD0, 8'hC0};

    function automatic logic [DW+3:0] flit(input logic vc, input logic head,
                                           input logic tail, input logic [DW-1:0] data);
        return {data, tail, head, vc, 1'b1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        channel_in = '0;
        out_ready  = 1'b0;
        reset      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++;
        if (flow_ctrl_out !== 2'b00) begin fails++; $display("FAIL reset_flow_ctrl: got %b expected 00", flow_ctrl_out); end
        tests++;
        if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
        $display("[TB] reset: out_valid=%b flow=%b error=%b", out_valid, flow_ctrl_out, error);
        do_reset();
    endtask

    task automatic test_single_packet;
        logic       e_valid [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] e_flow  [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            channel_in = (k < 3) ? flit(1'b0, k == 0, k == 2, DW'(k + 1)) : '0;
            tick();
            tests++;
            if (out_valid !== e_valid[k] || flow_ctrl_out !== e_flow[k]) begin
                fails++;
                $display("FAIL single_pkt_ctl[%0d]: got valid=%b flow=%b expected valid=%b flow=%b",
                         k, out_valid, flow_ctrl_out, e_valid[k], e_flow[k]);
            end
            if (k < 3) begin
                tests++;
                if (out_data !== DW'(k + 1) || out_vc !== 1'b0 || out_head !== (k == 0) || out_tail !== (k == 2)) begin
                    fails++;
                    $display("FAIL single_pkt_flit[%0d]: got vc=%b h=%b t=%b data=%h expected vc=0 h=%b t=%b data=%h",
                             k, out_vc, out_head, out_tail, out_data, k == 0, k == 2, DW'(k + 1));
                end
            end
            $display("[TB] single_pkt cycle %0d: valid=%b data=%h flow=%b", k, out_valid, out_data, flow_ctrl_out);
        end
    endtask

    task automatic test_back_pressure;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            channel_in = flit(1'b1, k == 0, k == 3, DW'(8'h10 + k));
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_vc !== 1'b1 || out_data !== DW'(8'h10) ||
                flow_ctrl_out !== 2'b00 || error !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b vc=%b data=%h flow=%b err=%b expected 1 1 10 00 0",
                         k, out_valid, out_vc, out_data, flow_ctrl_out, error);
            end
        end
        channel_in = flit(1'b1, 1'b1, 1'b1, DW'(8'h99));
        tick();
        channel_in = '0;
        tests++;
        if (error !== 1'b1 || flow_ctrl_out !== 2'b00 || out_data !== DW'(8'h10)) begin
            fails++;
            $display("FAIL backpressure_overflow: got err=%b flow=%b data=%h expected 1 00 10",
                     error, flow_ctrl_out, out_data);
        end
        $display("[TB] back_pressure: fifth flit, error=%b", error);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (k < 3) begin
                if (out_valid !== 1'b1 || out_data !== DW'(8'h11 + k) || flow_ctrl_out !== 2'b11) begin
                    fails++;
                    $display("FAIL backpressure_drain[%0d]: got valid=%b data=%h flow=%b expected 1 %h 11",
                             k, out_valid, out_data, flow_ctrl_out, DW'(8'h11 + k));
                end
            end else begin
                if (out_valid !== 1'b0 || error !== 1'b1) begin
                    fails++;
                    $display("FAIL backpressure_dropped[%0d]: got valid=%b err=%b expected 0 1", k, out_valid, error);
                end
            end
        end
    endtask

    task automatic test_interleaved;
        logic       got_vc [$];
        logic [7:0] got_dt [$];
        logic [1:0] exp_flow;
        do_reset();
        out_ready = 1'b1;
        exp_flow  = 2'b00;
        for (int k = 0; k < 16; k++) begin
            channel_in = (k < 8) ? flit(il_vc[k], il_hd[k], il_tl[k], DW'(il_dt[k])) : '0;
            tick();
            tests++;
            if (flow_ctrl_out !== exp_flow) begin
                fails++;
                $display("FAIL interleave_credit[%0d]: got %b expected %b", k, flow_ctrl_out, exp_flow);
            end
            exp_flow = 2'b00;
            if (out_valid === 1'b1) begin
                got_vc.push_back(out_vc);
                got_dt.push_back(out_data[7:0]);
                exp_flow = {out_vc, 1'b1};
            end
        end
        tests++;
        if (got_vc.size() != 8) begin
            fails++;
            $display("FAIL interleave_count: got %0d flits expected 8", got_vc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_vc[i] !== ex_vc[i] || got_dt[i] !== ex_dt[i]) begin
                    fails++;
                    $display("FAIL interleave_order[%0d]: got vc=%0d data=%h expected vc=%0d data=%h",
                             i, got_vc[i], got_dt[i], ex_vc[i], ex_dt[i]);
                end
                $display("[TB] interleave out %0d: vc=%0d data=%h", i, got_vc[i], got_dt[i]);
            end
        end
    endtask

    task automatic test_framing;
        do_reset();
        out_ready  = 1'b1;
        channel_in = flit(1'b0, 1'b0, 1'b0, DW'(8'h55));
        tick();
        tests++;
        if (error !== 1'b1) begin fails++; $display("FAIL framing_set: got %b expected 1", error); end
        for (int k = 0; k < 6; k++) begin
            channel_in = flit(1'($urandom_range(0, 1)), 1'b1, 1'b1, DW'($urandom));
            tick();
            tests++;
            if (error !== 1'b1) begin fails++; $display("FAIL framing_sticky[%0d]: got %b expected 1", k, error); end
        end
        channel_in = '0;
        $display("[TB] framing: error=%b after further traffic", error);
    endtask

    task automatic test_full_dequeue;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            channel_in = flit(1'b0, k == 0, 1'b0, DW'(8'h20 + k));
            tick();
        end
        channel_in = flit(1'b0, 1'b0, 1'b1, DW'(8'h24));
        out_ready  = 1'b1;
        tick();
        channel_in = '0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== DW'(8'h21 + k) || error !== 1'b0) begin
                fails++;
                $display("FAIL full_deq_flit[%0d]: got valid=%b data=%h err=%b expected 1 %h 0",
                         k, out_valid, out_data, error, DW'(8'h21 + k));
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL full_deq_end: got valid=%b err=%b expected 0 0", out_valid, error);
        end
        $display("[TB] full_dequeue: fifth flit kept, error=%b", error);
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        out_ready  = 1'b0;
        channel_in = flit(1'b1, 1'b0, 1'b0, DW'(8'h77));
        tick();
        channel_in = flit(1'b0, 1'b1, 1'b0, DW'(8'h30));
        tick();
        channel_in = flit(1'b0, 1'b0, 1'b0, DW'(8'h31));
        out_ready  = 1'b1;
        tick();
        channel_in = '0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(8'h30) || flow_ctrl_out !== 2'b11 || error !== 1'b1) begin
            fails++;
            $display("FAIL midpkt_pre: got valid=%b data=%h flow=%b err=%b expected 1 30 11 1",
                     out_valid, out_data, flow_ctrl_out, error);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || flow_ctrl_out !== 2'b00 || error !== 1'b0) begin
            fails++;
            $display("FAIL midpkt_reset: got valid=%b flow=%b err=%b expected 0 00 0",
                     out_valid, flow_ctrl_out, error);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0 || flow_ctrl_out !== 2'b00) begin
                fails++;
                $display("FAIL midpkt_after[%0d]: got valid=%b flow=%b expected 0 00", k, out_valid, flow_ctrl_out);
            end
        end
        $display("[TB] reset_mid_packet: buffered flits discarded");
    endtask

    task automatic test_random;
        flit_t      q0 [$];
        flit_t      q1 [$];
        int         rem [2];
        logic       prio, locked, lock_vc, stalled, stall_vc;
        logic       exp_sel, exp_valid, ready, vc, hd, tl;
        logic [1:0] exp_flow;
        flit_t      front, popped;
        logic [DW-1:0] d;
        int         n_deq;
        do_reset();
        rem[0] = 0; rem[1] = 0;
        prio = 1'b0; locked = 1'b0; lock_vc = 1'b0; stalled = 1'b0; stall_vc = 1'b0;
        exp_flow = 2'b00;
        n_deq = 0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            tests++;
            if (flow_ctrl_out !== exp_flow) begin
                fails++;
                $display("FAIL rand_credit[%0d]: got %b expected %b", cyc, flow_ctrl_out, exp_flow);
            end
            tests++;
            if (error !== 1'b0) begin fails++; $display("FAIL rand_error[%0d]: got %b expected 0", cyc, error); end

            // Which VC the terminal should be looking at this cycle.
            if (locked) exp_sel = lock_vc;
            else if (stalled) exp_sel = stall_vc;
            else if ((prio ? q1.size() : q0.size()) != 0) exp_sel = prio;
            else if ((prio ? q0.size() : q1.size()) != 0) exp_sel = ~prio;
            else exp_sel = prio;
            exp_valid = (exp_sel ? q1.size() : q0.size()) != 0;

            tests++;
            if (out_valid !== exp_valid) begin
                fails++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, out_valid, exp_valid);
            end
            if (exp_valid) begin
                front = exp_sel ? q1[0] : q0[0];
                tests++;
                if (out_vc !== exp_sel || {out_tail, out_head, out_data} !== front) begin
                    fails++;
                    $display("FAIL rand_flit[%0d]: got vc=%b flit=%h expected vc=%b flit=%h",
                             cyc, out_vc, {out_tail, out_head, out_data}, exp_sel, front);
                end
            end

            ready = (cyc >= 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = ready;
            exp_flow = 2'b00;
            stalled  = exp_valid && !ready;
            stall_vc = exp_sel;
            if (exp_valid && ready) begin
                popped = exp_sel ? q1.pop_front() : q0.pop_front();
                n_deq++;
                exp_flow = {exp_sel, 1'b1};
                prio = ~exp_sel;
                if (popped[DW+1]) locked = 1'b0;
                else if (popped[DW]) begin locked = 1'b1; lock_vc = exp_sel; end
            end

            channel_in = '0;
            vc = 1'($urandom_range(0, 1));
            if (cyc >= 2000 && rem[vc] == 0) vc = ~vc;
            if (((cyc < 2000 && $urandom_range(0, 9) < 6) || (cyc >= 2000 && rem[vc] > 0)) &&
                (vc ? q1.size() : q0.size()) < DEPTH) begin
                hd = (rem[vc] == 0);
                if (hd) rem[vc] = $urandom_range(1, 4);
                tl = (rem[vc] == 1);
                rem[vc]--;
                d = {$urandom, $urandom};
                channel_in = flit(vc, hd, tl, d);
                if (vc) q1.push_back({tl, hd, d});
                else    q0.push_back({tl, hd, d});
            end
            tick();
        end
        channel_in = '0;
        tests++;
        if (q0.size() != 0 || q1.size() != 0 || rem[0] != 0 || rem[1] != 0) begin
            fails++;
            $display("FAIL rand_drain: got %0d/%0d flits left, %0d/%0d open, expected all 0",
                     q0.size(), q1.size(), rem[0], rem[1]);
        end
        $display("[TB] random: %0d flits delivered", n_deq);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_pressure();
        test_interleaved();
        test_framing();
        test_full_dequeue();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_ejector.md
ROUTER_EJECTOR -- requirements
Module: router_ejector

Interface
REQ-001 Parameter BUF_DEPTH, default 4, flits buffered per VC; SHALL equal the upstream router's per-VC credit count.
REQ-002 Parameter DATA_WIDTH, default 64, payload bits per flit; channel width is DATA_WIDTH+4 (68).
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 channel_in  input  68  flit from the router output port: [0] valid, [1] vc, [2] head, [3] tail, [4:67] data.
REQ-006 flow_ctrl_out  output  2  credit to the router: [0] credit valid, [1] credit vc.
REQ-007 out_valid/out_ready  output/input  1/1  terminal-side flit handshake.
REQ-008 out_vc, out_head, out_tail, out_data  output  1,1,1,64  flit fields presented with out_valid.
REQ-009 error  output  1  sticky protocol-error flag.

Function
REQ-010 The block SHALL implement two VCs, each with a BUF_DEPTH-entry FIFO.
REQ-011 A flit with channel_in[0]=1 SHALL be written to FIFO[vc] at the next rising edge; the block never back-pressures the channel.
REQ-012 Write to a full FIFO: the block SHALL drop the flit and set error (overflow).
REQ-013 Per-VC receive FSM, states IDLE/IN_PKT: IDLE+head+!tail -> IN_PKT; IN_PKT+tail -> IDLE; head+tail stays IDLE.
REQ-014 Framing error: a non-head flit in IDLE, or a head flit in IN_PKT, SHALL set error; the flit is still stored if space is available.
REQ-015 Output selection: when no packet is in flight on the output, round-robin among non-empty VCs, with priority rotating to the VC after the last served.
REQ-016 After a head flit is dequeued, selection SHALL stay locked on that VC until its tail flit is dequeued (packets not interleaved at the output).
REQ-017 out_valid SHALL be asserted when the selected VC FIFO is non-empty; out_* fields SHALL come from that FIFO head, with no combinational path from channel_in.
REQ-018 Minimum latency: a flit written at edge t SHALL appear on out_* in the cycle after edge t (written on edge t, visible the following cycle).
REQ-019 A dequeue occurs when out_valid && out_ready; out_* SHALL stay stable while out_valid && !out_ready.
REQ-020 Each dequeue on VC v SHALL produce flow_ctrl_out = {1,v} for exactly the cycle after the dequeue; otherwise flow_ctrl_out = 2'b00.
REQ-021 Simultaneous write and dequeue on the same VC SHALL both take effect; a full FIFO with a simultaneous dequeue SHALL accept the write without overflow.
REQ-022 FIFO pointers SHALL wrap modulo BUF_DEPTH; occupancy counters SHALL be clog2(BUF_DEPTH+1) bits wide.
REQ-023 error SHALL remain set until reset.

Reset
REQ-024 While reset=0: FIFOs empty, FSMs in IDLE, output lock cleared, round-robin priority on VC0, out_valid=0, flow_ctrl_out=2'b00, error=0.
REQ-025 Reset asserted mid-packet SHALL discard all buffered flits and issue no credits for them.
REQ-026 Reset deassertion SHALL take effect at the first rising edge after release; the first flit can be accepted on that edge.

Structure
REQ-027 A shared package SHALL hold the channel field offsets, the flow-control field offsets, the VC count (2), and the FSM state typedef.
REQ-028 The per-VC buffer SHALL be a sub-module ejector_vc_fifo, instantiated twice.

Verification
REQ-029 Single packet: head/body/tail on VC0 (data 0x1,0x2,0x3), out_ready=1 -> three flits in order; three credits {1,0} on consecutive cycles.
REQ-030 Back-pressure: out_ready=0, four flits on VC1 -> out_valid held, no credits; a fifth flit on VC1 -> error=1.
REQ-031 Interleaved input: packets on VC0 and VC1 arriving alternately -> output is the complete VC0 packet, then the complete VC1 packet; RR priority then favours VC0.
REQ-032 Framing: body flit on idle VC0 -> error=1 next cycle; error stays 1 through further traffic.
REQ-033 Full-plus-dequeue: VC0 full and out_ready=1 while a fifth flit arrives -> flit stored, error stays 0.
REQ-034 Reset mid-packet: assert reset with two flits buffered -> out_valid=0, flow_ctrl_out=00, error=0 immediately; no credits after release.
